softmax_result_stream: RTL and testbench



---
 rtl/softmax_pkg.sv | 15 +
 rtl/softmax_result_stream_sync_fifo.sv | 45 ++++
 rtl/softmax_result_stream.sv | 157 +++++++++++++++
 tb/tb_softmax_result_stream.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax result streaming stage.
package softmax_pkg;
  localparam int PROB_W_DEF    = 16;
  localparam int ID_W_DEF      = 8;
  localparam int FRAME_LEN_DEF = 4800;
  localparam int WORD_W        = 32;
  localparam int CNT_W         = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [WORD_W-1:0] pack_result(input logic [PROB_W_DEF-1:0] prob,
                                                    input logic [ID_W_DEF-1:0]   id);
    return {{(WORD_W-PROB_W_DEF-ID_W_DEF){1'b0}}, id, prob};
  endfunction
endpackage

// File: rtl/softmax_result_stream_sync_fifo.sv
// Single-clock FIFO with synchronous flush; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/softmax_result_stream.sv
// Buffers non-stallable softmax results and streams them as 32-bit AXI4-Stream beats.
// Define SOFTMAX_RS_CKSUM_EN to append an XOR checksum beat carrying tlast.
module softmax_result_stream
  import softmax_pkg::*;
#(
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int PROB_W     = PROB_W_DEF,
  parameter int ID_W       = ID_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_start,
  input  logic              in_valid,
  input  logic [PROB_W-1:0] in_prob,
  input  logic [ID_W-1:0]   in_id,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              frame_done,
  output logic              overflow,
  output logic [15:0]       beat_cnt
);
  localparam logic [CNT_W-1:0] DATA_N    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);
`ifdef SOFTMAX_RS_CKSUM_EN
  localparam logic [CNT_W-1:0] BEATS        = CNT_W'(FRAME_LEN + 1);
  localparam logic             LAST_ON_DATA = 1'b0;
`else
  localparam logic [CNT_W-1:0] BEATS        = CNT_W'(FRAME_LEN);
  localparam logic             LAST_ON_DATA = 1'b1;
`endif

  state_t             r_state;
  logic [WORD_W-1:0]  r_tdata;
  logic               r_tvalid;
  logic               r_tlast;
  logic               r_frame_done;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   r_wr_cnt;
  logic [CNT_W-1:0]   r_ld_cnt;

  logic               w_run;
  logic               w_hs;
  logic               w_ld_free;
  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_ld_ck;
  logic               w_full;
  logic               w_empty;
  logic [WORD_W-1:0]  w_din;
  logic [WORD_W-1:0]  w_dout;
  logic [WORD_W-1:0]  w_ck_word;

  assign w_run     = (r_state == RUN) && !frame_start;
  assign w_hs      = r_tvalid && m_axis_tready;
  assign w_ld_free = !r_tvalid || w_hs;
  // r_ld_cnt counts words placed in the output register, so tlast is known at load time.
  assign w_pop     = w_run && w_ld_free && !w_empty && (r_ld_cnt < DATA_N);
  assign w_accept  = w_run && in_valid && (r_wr_cnt < DATA_N);
  assign w_push    = w_accept && (!w_full || w_pop);
  assign w_drop    = w_accept && w_full && !w_pop;
  assign w_din     = pack_result(in_prob, in_id);

`ifdef SOFTMAX_RS_CKSUM_EN
  logic [WORD_W-1:0] r_cksum;

  assign w_ld_ck   = w_run && w_ld_free && (r_ld_cnt == DATA_N);
  assign w_ck_word = r_cksum;

  always_ff @(posedge clk) begin
    if (!rstn || frame_start) r_cksum <= '0;
    else if (w_pop)           r_cksum <= r_cksum ^ w_dout;
  end
`else
  assign w_ld_ck   = 1'b0;
  assign w_ck_word = '0;
`endif

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (frame_start),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_beat_cnt   <= '0;
      r_wr_cnt     <= '0;
      r_ld_cnt     <= '0;
    end else if (frame_start) begin
      r_state      <= RUN;
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_beat_cnt   <= '0;
      r_wr_cnt     <= '0;
      r_ld_cnt     <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_push) r_wr_cnt   <= r_wr_cnt + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_pop) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_dout;
        r_tlast  <= LAST_ON_DATA && (r_ld_cnt == LAST_DATA);
        r_ld_cnt <= r_ld_cnt + 1'b1;
      end else if (w_ld_ck) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_ck_word;
        r_tlast  <= 1'b1;
        r_ld_cnt <= r_ld_cnt + 1'b1;
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
      if (w_hs && (r_beat_cnt != BEATS)) r_beat_cnt <= r_beat_cnt + 1'b1;
      case (r_state)
        RUN: begin
          if (w_hs && r_tlast) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign frame_done    = r_frame_done;
  assign overflow      = r_overflow;
  assign beat_cnt      = r_beat_cnt;
endmodule

// File: tb/tb_softmax_result_stream.sv
// Directed bench: an 8-beat instance for framing/abort and a 4800-beat instance
// for overflow and randomized-backpressure streaming.
module tb_softmax_result_stream;
`ifdef SOFTMAX_RS_CKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NA = 8 + CK;
  localparam int LB = 4800;
  localparam int NB = LB + CK;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        a_fs = 0, a_iv = 0, a_tready = 0;
  logic [15:0] a_prob = 0;
  logic [7:0]  a_id = 0;
  logic [31:0] a_tdata;
  logic        a_tvalid, a_tlast, a_done, a_ovf;
  logic [15:0] a_bcnt;
  logic        b_fs = 0, b_iv = 0, b_tready = 0;
  logic [15:0] b_prob = 0;
  logic [7:0]  b_id = 0;
  logic [31:0] b_tdata;
  logic        b_tvalid, b_tlast, b_done, b_ovf;
  logic [15:0] b_bcnt;

  int total = 0;
  int bad = 0;
  logic [31:0] qa[$];
  logic        qla[$];
  logic [31:0] qb[$];
  logic        qlb[$];
  logic [31:0] exp_a [8];
  int          a_done_cnt = 0;
  logic        a_last_hs_prev = 1'b0;

  always #5 clk = ~clk;

  softmax_result_stream #(.FRAME_LEN(8), .FIFO_DEPTH(16)) dut_a (
    .clk(clk), .rstn(rstn), .frame_start(a_fs), .in_valid(a_iv), .in_prob(a_prob),
    .in_id(a_id), .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(a_tready), .m_axis_tlast(a_tlast), .frame_done(a_done),
    .overflow(a_ovf), .beat_cnt(a_bcnt));

  softmax_result_stream #(.FRAME_LEN(LB), .FIFO_DEPTH(16)) dut_b (
    .clk(clk), .rstn(rstn), .frame_start(b_fs), .in_valid(b_iv), .in_prob(b_prob),
    .in_id(b_id), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(b_tready), .m_axis_tlast(b_tlast), .frame_done(b_done),
    .overflow(b_ovf), .beat_cnt(b_bcnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Handshakes are captured mid-cycle, where inputs and outputs are stable.
  always @(negedge clk) begin
    if (a_tvalid && a_tready) begin
      qa.push_back(a_tdata);
      qla.push_back(a_tlast);
    end
    if (b_tvalid && b_tready) begin
      qb.push_back(b_tdata);
      qlb.push_back(b_tlast);
    end
    if (a_done) begin
      a_done_cnt++;
      chk("a_done_follows_last", 32'(a_last_hs_prev), 32'd1);
    end
    a_last_hs_prev = a_tvalid && a_tready && a_tlast;
  end

  task automatic check_a_frame(input string tag);
    logic [31:0] x;
    logic [31:0] e;
    x = '0;
    for (int k = 0; k < 8; k++) x ^= exp_a[k];
    for (int k = 0; k < 200 && qa.size() < NA; k++) step();
    step();
    step();
    chk({tag, "_nbeats"}, 32'(qa.size()), 32'(NA));
    for (int k = 0; k < NA && k < qa.size(); k++) begin
      e = (k < 8) ? exp_a[k] : x;
      chk($sformatf("%s_data%0d", tag, k), qa[k], e);
      chk($sformatf("%s_last%0d", tag, k), 32'(qla[k]), 32'(k == NA - 1));
    end
    chk({tag, "_beat_cnt"}, 32'(a_bcnt), 32'(NA));
    chk({tag, "_overflow"}, 32'(a_ovf), 32'd0);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] xb;
    logic [31:0] e;
    int          fed;
    int          nlast;
    int          done_before;

    // Reset
    for (int k = 0; k < 5; k++) step();
    chk("rst_a_tvalid", 32'(a_tvalid), 32'd0);
    chk("rst_a_tdata", a_tdata, 32'd0);
    chk("rst_a_tlast", 32'(a_tlast), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_ovf", 32'(a_ovf), 32'd0);
    chk("rst_a_bcnt", 32'(a_bcnt), 32'd0);
    chk("rst_b_tvalid", 32'(b_tvalid), 32'd0);
    chk("rst_b_bcnt", 32'(b_bcnt), 32'd0);
    rstn = 1'b1;
    a_tready = 1'b1;
    a_iv = 1'b1;
    for (int k = 0; k < 3; k++) step();
    a_iv = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk("idle_in_no_tvalid", 32'(a_tvalid), 32'd0);
    chk("idle_in_no_beats", 32'(qa.size()), 32'd0);
    chk("idle_in_no_ovf", 32'(a_ovf), 32'd0);

    // Basic 8-beat frame at full rate
    qa.delete(); qla.delete();
    done_before = a_done_cnt;
    a_fs = 1'b1; step(); a_fs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_iv = 1'b1; a_prob = 16'(i); a_id = 8'(i + 1);
      exp_a[i] = {8'h00, 8'(i + 1), 16'(i)};
      step();
    end
    a_iv = 1'b0;
    check_a_frame("basic");
    chk("basic_done_pulses", 32'(a_done_cnt - done_before), 32'd1);
    chk("basic_done_low_after", 32'(a_done), 32'd0);

    // Results after the frame is complete are ignored
    qa.delete(); qla.delete();
    a_iv = 1'b1; step(); step(); a_iv = 1'b0;
    step(); step(); step();
    chk("done_in_no_tvalid", 32'(a_tvalid), 32'd0);
    chk("done_in_no_ovf", 32'(a_ovf), 32'd0);
    chk("done_bcnt_held", 32'(a_bcnt), 32'(NA));

    // Overflow: 20 results with the sink stalled
    b_fs = 1'b1; step(); b_fs = 1'b0;
    for (int i = 0; i < 20; i++) begin
      b_iv = 1'b1; b_prob = 16'(100 + i); b_id = 8'(i);
      step();
    end
    b_iv = 1'b0;
    step(); step(); step();
    chk("ovf_flag", 32'(b_ovf), 32'd1);
    chk("ovf_tvalid", 32'(b_tvalid), 32'd1);
    chk("ovf_first_word", b_tdata, {8'h00, 8'd0, 16'd100});
    held = b_tdata;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("stall_stable%0d", k), b_tdata, held);
      chk($sformatf("stall_valid%0d", k), 32'(b_tvalid), 32'd1);
    end
    b_tready = 1'b1;
    for (int k = 0; k < 100 && qb.size() < 17; k++) step();
    for (int k = 0; k < 5; k++) step();
    chk("ovf_nbeats", 32'(qb.size()), 32'd17);
    for (int k = 0; k < 17 && k < qb.size(); k++) begin
      chk($sformatf("ovf_data%0d", k), qb[k], {8'h00, 8'(k), 16'(100 + k)});
      chk($sformatf("ovf_last%0d", k), 32'(qlb[k]), 32'd0);
    end
    chk("ovf_beat_cnt", 32'(b_bcnt), 32'd17);
    chk("ovf_drained", 32'(b_tvalid), 32'd0);

    // Abort after 3 of 8 beats, then a clean restart with words 1..8
    qa.delete(); qla.delete();
    a_tready = 1'b0;
    a_fs = 1'b1; step(); a_fs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_iv = 1'b1; a_prob = 16'(50 + i); a_id = 8'(i);
      step();
    end
    a_iv = 1'b0;
    step();
    a_tready = 1'b1;
    step(); step(); step();
    chk("abort_pre_bcnt", 32'(a_bcnt), 32'd3);
    a_tready = 1'b0;
    a_fs = 1'b1; step(); a_fs = 1'b0;
    chk("abort_tvalid", 32'(a_tvalid), 32'd0);
    chk("abort_bcnt", 32'(a_bcnt), 32'd0);
    step(); step();
    chk("abort_stays_empty", 32'(a_tvalid), 32'd0);
    qa.delete(); qla.delete();
    done_before = a_done_cnt;
    a_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_iv = 1'b1; a_prob = 16'(i + 1); a_id = 8'd0;
      exp_a[i] = 32'(i + 1);
      step();
    end
    a_iv = 1'b0;
    check_a_frame("restart");
    chk("restart_done_pulses", 32'(a_done_cnt - done_before), 32'd1);

    // Full 4800-result frame under random backpressure
    qb.delete(); qlb.delete();
    b_fs = 1'b1; step(); b_fs = 1'b0;
    chk("rand_ovf_cleared", 32'(b_ovf), 32'd0);
    fed = 0;
    for (int c = 0; c < 40000 && (fed < LB || qb.size() < NB); c++) begin
      b_tready = 1'($urandom_range(0, 1));
      b_iv = ((c % 4) == 0) && (fed < LB);
      if (b_iv) begin
        b_prob = 16'(fed * 7 + 3);
        b_id = 8'(fed);
        fed++;
      end
      step();
    end
    b_iv = 1'b0;
    b_tready = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("rand_nbeats", 32'(qb.size()), 32'(NB));
    xb = '0;
    nlast = 0;
    for (int k = 0; k < NB && k < qb.size(); k++) begin
      e = (k < LB) ? {8'h00, 8'(k), 16'(k * 7 + 3)} : xb;
      if (k < LB) xb ^= e;
      chk($sformatf("rand_data%0d", k), qb[k], e);
      if (qlb[k]) nlast++;
    end
    chk("rand_one_tlast", 32'(nlast), 32'd1);
    if (qlb.size() > 0) chk("rand_tlast_pos", 32'(qlb[qlb.size() - 1]), 32'd1);
    chk("rand_ovf", 32'(b_ovf), 32'd0);
    chk("rand_beat_cnt", 32'(b_bcnt), 32'(NB));

    // Reset in the middle of a frame
    qa.delete(); qla.delete();
    a_tready = 1'b0;
    a_fs = 1'b1; step(); a_fs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_iv = 1'b1; step();
    end
    a_iv = 1'b0;
    step();
    chk("midrst_pre_tvalid", 32'(a_tvalid), 32'd1);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("midrst_tvalid", 32'(a_tvalid), 32'd0);
    chk("midrst_tlast", 32'(a_tlast), 32'd0);
    a_tready = 1'b1;
    step(); step(); step();
    chk("midrst_no_beats", 32'(qa.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
